// File: rtl/mtm_alu_deserializer.sv
// Serial input deserializer for the mtm_alu link: rebuilds 8 DATA frames plus a CMD frame
// into {B, A, op}, checks packet length, CRC-4 and opcode, and pulses out_valid once per packet.
module mtm_alu_deserializer #(
   parameter int unsigned DATA_FRAMES = 8,
   parameter int unsigned OP_W        = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sin,
   output logic            out_valid,
   output logic [31:0]     out_a,
   output logic [31:0]     out_b,
   output logic [OP_W-1:0] out_op,
   output logic [2:0]      out_err
);

   localparam int unsigned CNT_W = $clog2(DATA_FRAMES + 2);
   localparam int unsigned MSG_W = 65 + OP_W;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StType    = 2'd1;
   localparam logic [1:0] StPayload = 2'd2;
   localparam logic [1:0] StStop    = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic             type_q, type_d;
   logic [7:0]       shift_q, shift_d;
   logic [63:0]      data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_data_q, err_data_d;
   logic             out_valid_q, out_valid_d;
   logic [31:0]      out_a_q, out_a_d;
   logic [31:0]      out_b_q, out_b_d;
   logic [OP_W-1:0]  out_op_q, out_op_d;
   logic [2:0]       out_err_q, out_err_d;

   logic [OP_W-1:0]  rx_op;
   logic [3:0]       rx_crc;
   logic [3:0]       calc_crc;
   logic             pkt_err_data;
   logic             pkt_err_crc;
   logic             pkt_err_op;

   // Serial CRC-4 (x^4+x+1, init 0) over the message, MSB first.
   function automatic logic [3:0] crc4(input logic [MSG_W-1:0] msg);
      logic [3:0] c;
      logic       fb;
      c = 4'b0000;
      for (int i = MSG_W - 1; i >= 0; i--) begin
         fb = c[3] ^ msg[i];
         c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
      end
      return c;
   endfunction

   // CMD payload in shift_q: {ignored, op, crc}.
   assign rx_op    = shift_q[4 +: OP_W];
   assign rx_crc   = shift_q[3:0];
   assign calc_crc = crc4({data_q, 1'b1, rx_op});

   // Errors are mutually exclusive with priority data > crc > op.
   assign pkt_err_data = err_data_q || (cnt_q != CNT_W'(DATA_FRAMES));
   assign pkt_err_crc  = !pkt_err_data && (calc_crc != rx_crc);
   assign pkt_err_op   = !pkt_err_data && !pkt_err_crc && rx_op[1];

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      type_d      = type_q;
      shift_d     = shift_q;
      data_d      = data_q;
      cnt_d       = cnt_q;
      err_data_d  = err_data_q;
      out_valid_d = 1'b0;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_op_d    = out_op_q;
      out_err_d   = out_err_q;

      case (state_q)
         StIdle: begin
            if (!sin) state_d = StType;
         end
         StType: begin
            type_d    = sin;
            bit_cnt_d = 3'd7;
            state_d   = StPayload;
         end
         StPayload: begin
            shift_d = {shift_q[6:0], sin};
            if (bit_cnt_q == 3'd0) state_d = StStop;
            else bit_cnt_d = bit_cnt_q - 3'd1;
         end
         StStop: begin
            state_d = StIdle;
            if (!sin) begin
               // Framing error: drop the frame, poison the whole packet.
               err_data_d = 1'b1;
            end else if (!type_q) begin
               data_d = {data_q[55:0], shift_q};
               if (cnt_q != CNT_W'(DATA_FRAMES + 1)) cnt_d = cnt_q + CNT_W'(1);
            end else begin
               out_valid_d = 1'b1;
               out_op_d    = rx_op;
               out_err_d   = {pkt_err_data, pkt_err_crc, pkt_err_op};
               if (pkt_err_data || pkt_err_crc || pkt_err_op) begin
                  out_a_d = 32'd0;
                  out_b_d = 32'd0;
               end else begin
                  out_a_d = data_q[31:0];
                  out_b_d = data_q[63:32];
               end
               cnt_d      = '0;
               err_data_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= 3'd0;
         type_q      <= 1'b0;
         shift_q     <= 8'd0;
         data_q      <= 64'd0;
         cnt_q       <= '0;
         err_data_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_a_q     <= 32'd0;
         out_b_q     <= 32'd0;
         out_op_q    <= '0;
         out_err_q   <= 3'd0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         type_q      <= type_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         err_data_q  <= err_data_d;
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         out_op_q    <= out_op_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_op    = out_op_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for mtm_alu_deserializer: frames are driven one bit per clock and every
// out_valid pulse is captured on the falling edge for comparison against hand-built values.
module tb_mtm_alu_deserializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sin;
   logic        out_valid;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [2:0]  out_op;
   logic [2:0]  out_err;

   int errors = 0;
   int checks = 0;
   int vcnt   = 0;
   logic [31:0] cap_a, cap_b;
   logic [2:0]  cap_op, cap_err;

   mtm_alu_deserializer #(
      .DATA_FRAMES(8),
      .OP_W(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sin(sin),
      .out_valid(out_valid),
      .out_a(out_a),
      .out_b(out_b),
      .out_op(out_op),
      .out_err(out_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         vcnt++;
         cap_a   = out_a;
         cap_b   = out_b;
         cap_op  = out_op;
         cap_err = out_err;
      end
   end

   function automatic logic [3:0] crc4(input logic [67:0] m);
      logic [3:0] c;
      logic       fb;
      c = 4'b0000;
      for (int i = 67; i >= 0; i--) begin
         fb = c[3] ^ m[i];
         c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
      end
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      sin = b;
      tick();
   endtask

   task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      send_bit(typ);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      send_bit(stop);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   // nframes > 8 prepends filler bytes; nframes < 8 sends only the leading bytes of {b, a}.
   task automatic send_packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                              input logic [3:0] crc_xor, input int nframes, input int bad_idx);
      logic [63:0] d;
      logic [3:0]  crc;
      logic [7:0]  byt;
      int          j;
      d   = {b, a};
      crc = crc4({b, a, 1'b1, op}) ^ crc_xor;
      for (int i = 0; i < nframes; i++) begin
         j = (nframes > 8) ? i - (nframes - 8) : i;
         byt = (j < 0) ? 8'h55 : d[63 - 8 * j -: 8];
         send_frame(1'b0, byt, i != bad_idx);
      end
      send_frame(1'b1, {1'b0, op, crc}, 1'b1);
      idle(3);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sin   = 1'b1;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
      checks++; if (out_a !== 32'd0) begin errors++; $display("FAIL reset_a: got %h exp 0", out_a); end
      checks++; if (out_b !== 32'd0) begin errors++; $display("FAIL reset_b: got %h exp 0", out_b); end
      checks++; if (out_op !== 3'd0) begin errors++; $display("FAIL reset_op: got %b exp 000", out_op); end
      checks++; if (out_err !== 3'd0) begin errors++; $display("FAIL reset_err: got %b exp 000", out_err); end
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_basic();
      for (int i = 0; i < 8; i++) send_frame(1'b0, 8'h00, 1'b1);
      send_frame(1'b1, 8'h0B, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b exp 1", out_valid); end
      checks++; if (out_err !== 3'b000) begin errors++; $display("FAIL basic_err: got %b exp 000", out_err); end
      checks++; if (out_op !== 3'b000) begin errors++; $display("FAIL basic_op: got %b exp 000", out_op); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b exp 0", out_valid); end
      idle(2);
   endtask

   task automatic test_back_to_back();
      int v0;
      v0 = vcnt;
      for (int i = 0; i < 8; i++) send_frame(1'b0, 8'h00, 1'b1);
      send_frame(1'b1, 8'h47, 1'b1);
      checks++; if (out_err !== 3'b000) begin errors++; $display("FAIL b2b_first_err: got %b exp 000", out_err); end
      checks++; if (out_op !== 3'b100) begin errors++; $display("FAIL b2b_first_op: got %b exp 100", out_op); end
      send_frame(1'b1, 8'h45, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got %b exp 1", out_valid); end
      checks++; if (out_err !== 3'b100) begin errors++; $display("FAIL b2b_second_err: got %b exp 100", out_err); end
      checks++; if (out_op !== 3'b100) begin errors++; $display("FAIL b2b_second_op: got %b exp 100", out_op); end
      idle(2);
      checks++; if (vcnt !== v0 + 2) begin errors++; $display("FAIL b2b_pulses: got %0d exp %0d", vcnt - v0, 2); end
   endtask

   task automatic test_crc();
      int v0;
      v0 = vcnt;
      send_packet(32'h01020304, 32'hA0B0C0D0, 3'b101, 4'b0001, 8, -1);
      checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL crc_bad_pulses: got %0d exp 1", vcnt - v0); end
      checks++; if (cap_err !== 3'b010) begin errors++; $display("FAIL crc_bad_err: got %b exp 010", cap_err); end
      checks++; if (cap_a !== 32'd0) begin errors++; $display("FAIL crc_bad_a: got %h exp 0", cap_a); end
      checks++; if (cap_op !== 3'b101) begin errors++; $display("FAIL crc_bad_op: got %b exp 101", cap_op); end
      send_packet(32'h01020304, 32'hA0B0C0D0, 3'b101, 4'b0000, 8, -1);
      checks++; if (vcnt !== v0 + 2) begin errors++; $display("FAIL crc_good_pulses: got %0d exp 2", vcnt - v0); end
      checks++; if (cap_err !== 3'b000) begin errors++; $display("FAIL crc_good_err: got %b exp 000", cap_err); end
      checks++; if (cap_b !== 32'h01020304) begin errors++; $display("FAIL crc_good_b: got %h exp 01020304", cap_b); end
      checks++; if (cap_a !== 32'hA0B0C0D0) begin errors++; $display("FAIL crc_good_a: got %h exp a0b0c0d0", cap_a); end
   endtask

   task automatic test_hold();
      int v0;
      v0 = vcnt;
      for (int i = 0; i < 3; i++) send_frame(1'b0, 8'hFF, 1'b1);
      idle(3);
      checks++; if (vcnt !== v0) begin errors++; $display("FAIL hold_no_pulse: got %0d exp 0", vcnt - v0); end
      checks++; if (out_a !== 32'hA0B0C0D0) begin errors++; $display("FAIL hold_a: got %h exp a0b0c0d0", out_a); end
      checks++; if (out_b !== 32'h01020304) begin errors++; $display("FAIL hold_b: got %h exp 01020304", out_b); end
      send_frame(1'b1, 8'h00, 1'b1);
      idle(3);
      checks++; if (cap_err !== 3'b100) begin errors++; $display("FAIL hold_short_err: got %b exp 100", cap_err); end
   endtask

   task automatic test_length();
      send_packet(32'h11223344, 32'h55667788, 3'b000, 4'b0000, 7, -1);
      checks++; if (cap_err !== 3'b100) begin errors++; $display("FAIL len7_err: got %b exp 100", cap_err); end
      send_packet(32'h11223344, 32'h55667788, 3'b000, 4'b0000, 9, -1);
      checks++; if (cap_err !== 3'b100) begin errors++; $display("FAIL len9_err: got %b exp 100", cap_err); end
      checks++; if (cap_b !== 32'd0) begin errors++; $display("FAIL len9_b: got %h exp 0", cap_b); end
      send_packet(32'h11223344, 32'h55667788, 3'b000, 4'b0000, 8, -1);
      checks++; if (cap_err !== 3'b000) begin errors++; $display("FAIL len8_err: got %b exp 000", cap_err); end
      checks++; if (cap_a !== 32'h55667788) begin errors++; $display("FAIL len8_a: got %h exp 55667788", cap_a); end
   endtask

   task automatic test_bad_op();
      send_packet(32'hCAFEF00D, 32'h12345678, 3'b111, 4'b0000, 8, -1);
      checks++; if (cap_err !== 3'b001) begin errors++; $display("FAIL badop_err: got %b exp 001", cap_err); end
      checks++; if (cap_op !== 3'b111) begin errors++; $display("FAIL badop_op: got %b exp 111", cap_op); end
      checks++; if (cap_a !== 32'd0) begin errors++; $display("FAIL badop_a: got %h exp 0", cap_a); end
      send_packet(32'hCAFEF00D, 32'h12345678, 3'b010, 4'b0000, 8, -1);
      checks++; if (cap_err !== 3'b001) begin errors++; $display("FAIL badop010_err: got %b exp 001", cap_err); end
   endtask

   task automatic test_reset_mid();
      int v0;
      v0 = vcnt;
      for (int i = 0; i < 4; i++) send_frame(1'b0, 8'h3C, 1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rst_n = 1'b0;
      sin   = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      idle(4);
      checks++; if (vcnt !== v0) begin errors++; $display("FAIL rstmid_no_pulse: got %0d exp 0", vcnt - v0); end
      checks++; if (out_op !== 3'd0) begin errors++; $display("FAIL rstmid_op: got %b exp 000", out_op); end
      send_packet(32'hDEADBEEF, 32'h01234567, 3'b001, 4'b0000, 8, -1);
      checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL rstmid_pulses: got %0d exp 1", vcnt - v0); end
      checks++; if (cap_err !== 3'b000) begin errors++; $display("FAIL rstmid_err: got %b exp 000", cap_err); end
      checks++; if (cap_b !== 32'hDEADBEEF) begin errors++; $display("FAIL rstmid_b: got %h exp deadbeef", cap_b); end
      checks++; if (cap_a !== 32'h01234567) begin errors++; $display("FAIL rstmid_a: got %h exp 01234567", cap_a); end
      checks++; if (cap_op !== 3'b001) begin errors++; $display("FAIL rstmid_op2: got %b exp 001", cap_op); end
   endtask

   task automatic test_framing();
      int v0;
      v0 = vcnt;
      send_packet(32'hDEADBEEF, 32'h01234567, 3'b100, 4'b0000, 8, 2);
      checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL frame_pulses: got %0d exp 1", vcnt - v0); end
      checks++; if (cap_err !== 3'b100) begin errors++; $display("FAIL frame_err: got %b exp 100", cap_err); end
      checks++; if (cap_a !== 32'd0) begin errors++; $display("FAIL frame_a: got %h exp 0", cap_a); end
   endtask

   task automatic test_stuck_low();
      int v0;
      v0 = vcnt;
      for (int i = 0; i < 22; i++) send_bit(1'b0);
      idle(3);
      checks++; if (vcnt !== v0) begin errors++; $display("FAIL stuck_no_pulse: got %0d exp 0", vcnt - v0); end
      send_packet(32'h0BADC0DE, 32'h00FF00FF, 3'b100, 4'b0000, 8, -1);
      checks++; if (cap_err !== 3'b100) begin errors++; $display("FAIL stuck_sticky_err: got %b exp 100", cap_err); end
      send_packet(32'h0BADC0DE, 32'h00FF00FF, 3'b100, 4'b0000, 8, -1);
      checks++; if (cap_err !== 3'b000) begin errors++; $display("FAIL stuck_clean_err: got %b exp 000", cap_err); end
      checks++; if (cap_b !== 32'h0BADC0DE) begin errors++; $display("FAIL stuck_clean_b: got %h exp 0badc0de", cap_b); end
   endtask

   initial begin
      sin   = 1'b1;
      rst_n = 1'b1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_crc();
      test_hold();
      test_length();
      test_bad_op();
      test_reset_mid();
      test_framing();
      test_stuck_low();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
